// File: rtl/fifo_slave.sv
// Bus slave with a 32-bit circular FIFO behind a small register map (DATA/STATUS/CTRL).
// Optional threshold interrupt and THRESH register at 0x03 when FIFO_SLAVE_IRQ_EN is defined.
module fifo_slave #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        s_sel,
   input  logic        s_wr,
   input  logic [7:0]  s_address,
   input  logic [31:0] s_din,
   output logic [31:0] s_dout,
   output logic        fifo_irq
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          overflow;
   logic          underflow;
   logic          empty;
   logic          full;
   logic          push_req;
   logic          pop_req;
   logic          ctrl_wr;
   logic          push_ok;
   logic          pop_ok;
   logic [31:0]   status;
   logic [31:0]   read_data;

`ifdef FIFO_SLAVE_IRQ_EN
   logic [PW:0]   thresh;
   logic          thresh_wr;
`endif

   assign empty    = (count == '0);
   assign full     = (count == FULL_COUNT);
   assign push_req = s_sel &&  s_wr && (s_address == 8'h00);
   assign pop_req  = s_sel && !s_wr && (s_address == 8'h00);
   assign ctrl_wr  = s_sel &&  s_wr && (s_address == 8'h02);
   assign push_ok  = push_req && !full;
   assign pop_ok   = pop_req && !empty;

   always_comb begin
      status        = '0;
      status[PW:0]  = count;
      status[8]     = empty;
      status[9]     = full;
      status[10]    = overflow;
      status[11]    = underflow;
   end

   // Popping an empty FIFO returns 0, so uninitialised storage never leaks out.
   always_comb begin
      read_data = '0;
      case (s_address)
         8'h00:   read_data = empty ? '0 : mem[rd_ptr];
         8'h01:   read_data = status;
`ifdef FIFO_SLAVE_IRQ_EN
         8'h03:   read_data[PW:0] = thresh;
`endif
         default: read_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= s_din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         s_dout    <= '0;
      end else begin
         if (ctrl_wr && s_din[0]) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
            count  <= count + (PW+1)'(1);
         end else if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
            count  <= count - (PW+1)'(1);
         end
         // Sticky error flags; only an explicit clear through CTRL drops them.
         if (ctrl_wr && s_din[1]) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (push_req && full)  overflow  <= 1'b1;
            if (pop_req  && empty) underflow <= 1'b1;
         end
         if (s_sel && !s_wr) s_dout <= read_data;
      end
   end

`ifdef FIFO_SLAVE_IRQ_EN
   assign thresh_wr = s_sel && s_wr && (s_address == 8'h03);

   // Interrupt is registered from the committed count, so it lags a count change by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         thresh   <= (PW+1)'(DEPTH/2);
         fifo_irq <= 1'b0;
      end else begin
         if (thresh_wr) thresh <= s_din[PW:0];
         fifo_irq <= (thresh != '0) && (count >= thresh);
      end
   end
`else
   assign fifo_irq = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_slave.sv
// Directed self-checking bench for fifo_slave (DEPTH=8); honours FIFO_SLAVE_IRQ_EN if defined.
module tb_fifo_slave;

   logic        clk;
   logic        reset_n;
   logic        s_sel;
   logic        s_wr;
   logic [7:0]  s_address;
   logic [31:0] s_din;
   logic [31:0] s_dout;
   logic        fifo_irq;

   int errors = 0;
   int checks = 0;
   logic [31:0] rd;

   fifo_slave #(.DEPTH(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .s_sel     (s_sel),
      .s_wr      (s_wr),
      .s_address (s_address),
      .s_din     (s_din),
      .s_dout    (s_dout),
      .fifo_irq  (fifo_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Each access is driven after a falling edge and completes at the next falling edge.
   task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
      s_sel = 1'b1; s_wr = 1'b1; s_address = addr; s_din = data;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
      s_sel = 1'b1; s_wr = 1'b0; s_address = addr; s_din = '0;
      @(negedge clk);
      data = s_dout;
   endtask

   task automatic idle();
      s_sel = 1'b0; s_wr = 1'b0; s_address = '0; s_din = '0;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_address = '0; s_din = '0;
      repeat (2) @(negedge clk);
      check_output("reset_dout", s_dout, 32'h0);
      check_output("reset_irq", {31'b0, fifo_irq}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      bus_read(8'h01, rd); check_output("status_after_reset", rd, 32'h0000_0100);
      idle();

      bus_write(8'h00, 32'h0000_1111);
      bus_write(8'h00, 32'h0000_2222);
      bus_read(8'h00, rd); check_output("pop_first", rd, 32'h0000_1111);
      bus_read(8'h00, rd); check_output("pop_second", rd, 32'h0000_2222);
      bus_read(8'h01, rd); check_output("status_after_pops", rd, 32'h0000_0100);
      idle();
      check_output("dout_hold_when_idle", s_dout, 32'h0000_0100);

      for (int i = 0; i < 9; i++) bus_write(8'h00, 32'hA000_0000 + i);
      bus_read(8'h01, rd); check_output("status_full_overflow", rd, 32'h0000_0608);
      for (int i = 0; i < 8; i++) begin
         bus_read(8'h00, rd); check_output($sformatf("pop_full_%0d", i), rd, 32'hA000_0000 + i);
      end
      bus_read(8'h01, rd); check_output("status_overflow_sticky", rd, 32'h0000_0500);
      bus_write(8'h02, 32'h2);
      bus_read(8'h01, rd); check_output("status_ovf_cleared", rd, 32'h0000_0100);

      bus_read(8'h00, rd); check_output("pop_empty_zero", rd, 32'h0);
      bus_read(8'h01, rd); check_output("status_underflow", rd, 32'h0000_0900);
      bus_write(8'h02, 32'h2);
      bus_read(8'h01, rd); check_output("status_udf_cleared", rd, 32'h0000_0100);

      for (int i = 0; i < 3; i++) bus_write(8'h00, 32'hB000_0000 + i);
      bus_read(8'h01, rd); check_output("status_count3", rd, 32'h0000_0003);
      bus_write(8'h02, 32'h1);
      bus_read(8'h01, rd); check_output("status_after_flush", rd, 32'h0000_0100);
      bus_write(8'h00, 32'h0000_0055);
      bus_read(8'h00, rd); check_output("pop_after_flush", rd, 32'h0000_0055);

      bus_write(8'h00, 32'hCCCC_0000);
      bus_read(8'h00, rd);
      bus_write(8'h00, 32'h1);
      bus_read(8'h00, rd);
      bus_write(8'h02, 32'h3);
      bus_read(8'h01, rd); check_output("flush_and_clear", rd, 32'h0000_0100);

      for (int i = 0; i < 5; i++) bus_write(8'h00, 32'hD000_0000 + i);
      bus_read(8'h01, rd); check_output("status_count5", rd, 32'h0000_0005);
      idle();
      reset_n = 1'b0;
      #1;
      check_output("async_reset_dout", s_dout, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bus_read(8'h01, rd); check_output("status_after_midreset", rd, 32'h0000_0100);
      bus_read(8'h00, rd); check_output("pop_after_midreset", rd, 32'h0);
      bus_write(8'h02, 32'h2);

      for (int i = 0; i < 12; i++) begin
         bus_write(8'h00, 32'hE000_0000 + 32'(i * 17));
         bus_read(8'h00, rd); check_output($sformatf("wrap_%0d", i), rd, 32'hE000_0000 + 32'(i * 17));
      end
      bus_read(8'h01, rd); check_output("status_after_wrap", rd, 32'h0000_0100);

      bus_write(8'h01, 32'hFFFF_FFFF);
      bus_write(8'h10, 32'hFFFF_FFFF);
      bus_read(8'h01, rd); check_output("status_write_ignored", rd, 32'h0000_0100);
      bus_read(8'h7F, rd); check_output("unmapped_read", rd, 32'h0);
      bus_write(8'h00, 32'h0000_0077);
      bus_read(8'h02, rd); check_output("ctrl_reads_zero", rd, 32'h0);
      bus_read(8'h01, rd); check_output("status_count1", rd, 32'h0000_0001);
      bus_write(8'h02, 32'h1);
      idle();

`ifdef FIFO_SLAVE_IRQ_EN
      bus_read(8'h03, rd); check_output("thresh_reset", rd, 32'h4);
      bus_write(8'h03, 32'hFFFF_FFF3);
      bus_read(8'h03, rd); check_output("thresh_readback", rd, 32'h3);
      for (int i = 0; i < 3; i++) bus_write(8'h00, 32'hF000_0000 + i);
      s_sel = 1'b0;
      check_output("irq_not_yet", {31'b0, fifo_irq}, 32'h0);
      idle();
      check_output("irq_rise", {31'b0, fifo_irq}, 32'h1);
      bus_read(8'h00, rd); check_output("irq_pop_data", rd, 32'hF000_0000);
      s_sel = 1'b0;
      check_output("irq_still_high", {31'b0, fifo_irq}, 32'h1);
      idle();
      check_output("irq_fall", {31'b0, fifo_irq}, 32'h0);
      bus_write(8'h03, 32'h0);
      bus_write(8'h00, 32'h1);
      idle();
      idle();
      check_output("irq_disabled_thresh0", {31'b0, fifo_irq}, 32'h0);
`else
      bus_write(8'h03, 32'h0000_0003);
      bus_read(8'h03, rd); check_output("thresh_unmapped", rd, 32'h0);
      for (int i = 0; i < 5; i++) bus_write(8'h00, 32'hF000_0000 + i);
      idle();
      idle();
      check_output("irq_tied_low", {31'b0, fifo_irq}, 32'h0);
      bus_read(8'h01, rd); check_output("status_count5_noirq", rd, 32'h0000_0005);
`endif
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
